debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//  Parametrised N-channel switch/button debouncer for board inputs feeding the CPU front panel and control logic.
//  Each channel has its own input synchroniser, stability counter and debounced level output.
//  Each channel also emits single-cycle rise and fall pulses.
//  All logic runs on the rising edge of one clock. Replaces per-button single-channel debouncers.
// PARAMETERS
//  CHANNELS     4      number of independent input channels (>=1)
//  CNT_W        16     stability counter width; elaboration error if LIMIT-1 > 2**CNT_W-1
//  LIMIT        1000   consecutive differing cycles required before clean flips (>=1)
//  SYNC_STAGES  2      synchroniser flops per channel (>=2)
//  RESET_VAL    1'b0   reset level of synchroniser flops and clean outputs (all channels)
// PORTS
//  clk      in   1         system clock; all state updates on posedge
//  rst      in   1         asynchronous active-low reset (asserted when 0)
//  enable   in   1         global enable; low freezes clean and clears counters
//  dirty    in   CHANNELS  raw asynchronous bouncing inputs
//  clean    out  CHANNELS  debounced levels, registered
//  rise     out  CHANNELS  1-cycle pulse, coincident with clean 0->1
//  fall     out  CHANNELS  1-cycle pulse, coincident with clean 1->0
//  busy     out  1         OR over channels of (counter != 0), registered
// BEHAVIOUR
//  Reset (rst==0, async):
//   - sync flops = RESET_VAL; clean = RESET_VAL; counters = 0
//   - rise = fall = 0; busy = 0
//   - Mid-operation reset discards in-progress counts; no pulse is emitted on reset or its release.
//  Per channel i, s = last synchroniser stage, each posedge with enable=1:
//   - s == clean[i]: counter <= 0 (bounce aborts the count; restart from 0)
//   - s != clean[i] and counter < LIMIT-1: counter <= counter+1
//   - s != clean[i] and counter == LIMIT-1:
//       clean[i] <= s; counter <= 0
//       rise[i] <= s; fall[i] <= ~s for exactly that cycle
//  Pulses: rise/fall default to 0 every cycle they are not set by the rule above.
//  Latency: a dirty step held stable gives clean change SYNC_STAGES+LIMIT posedges after the first edge sampling the new value.
//  LIMIT=1: clean follows s with 1 cycle delay; a bounce lasting >=1 cycle passes.
//  Counter never wraps: max value reached is LIMIT-1.
//  enable==0: synchronisers keep sampling; counters <= 0; clean held; rise/fall = 0.
//   - On enable re-assertion, counting restarts from 0.
//  Channels are fully independent; simultaneous flips on several channels are all reported in the same cycle.
//  busy reflects counters after the current update (registered alongside them).
//  No state machine beyond per-channel counter; no illegal states reachable.
// STRUCTURE
//  Sub-module debounce_channel (one instance per channel via generate).
//   - Ports: clk, rst, enable, dirty, clean, rise, fall, active.
//   - Params: CNT_W, LIMIT, SYNC_STAGES, RESET_VAL.
//  Top level: generate loop + busy OR-reduction register.
//  Shared package/header: default debounce LIMIT for the board clock and CNT_W derivation constant.
//   - No typedefs needed.
// TESTING (CHANNELS=4, LIMIT=8, SYNC_STAGES=2, RESET_VAL=0, CNT_W=4)
//  1. Reset: rst=0 with dirty=4'hF -> clean=0, rise=fall=0, busy=0; release rst -> no pulses.
//  2. Clean step: dirty[0] 0->1 held -> clean[0]=1 exactly 10 posedges later; rise[0]=1 for one cycle; busy high during count.
//  3. Bounce: dirty[1] high 5 cycles, low 1, high 20 -> count restarts; clean[1] rises 10 cycles after last 0->1; single rise.
//  4. Parallel: dirty=4'b1010 same cycle, then 4'b0000 after 30 cycles -> rise=4'b1010 one cycle, later fall=4'b1010 one cycle.
//  5. Enable: enable=0 mid-count (counter=5), hold 3 cycles, re-enable -> clean flips 8 cycles after re-enable, not earlier.
//  6. Reset mid-count: rst=0 at counter=6 on ch2 with clean[2]=1 -> clean[2]=0 immediately, no fall pulse.
//     After release with dirty[2]=1 held, rise after 10 cycles.

Source files
------------

// File: rtl/debounce_multi_pkg.sv
// Shared debounce constants for the board clock and the counter-width helper.
package debounce_multi_pkg;

  // Stability window in clock cycles for board buttons and switches.
  localparam int DEFAULT_LIMIT = 1000;

  // Default counter width; comfortably holds DEFAULT_LIMIT-1.
  localparam int DEFAULT_CNT_W = 16;

  // Smallest counter width able to hold limit-1 (never less than one bit).
  function automatic int min_cnt_w(input int limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, stability counter, clean level
// and single-cycle rise/fall pulses.
module debounce_channel
  import debounce_multi_pkg::*;
#(
  parameter int   CNT_W       = DEFAULT_CNT_W,
  parameter int   LIMIT       = DEFAULT_LIMIT,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic dirty,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic active
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   s;
  logic                   differs;
  logic                   at_limit;

  assign s        = sync_q[SYNC_STAGES-1];
  assign differs  = enable && (s != clean);
  assign at_limit = (cnt_q == CNT_MAX);

  // Next counter value: count while the synchronised input disagrees with
  // clean, restart on any agreement, on a flip, or while disabled.
  always_comb begin
    // NOTE: a default before any condition keeps this purely combinational;
    // a path that leaves cnt_d unassigned would infer a latch.
    cnt_d = '0;
    if (differs && !at_limit) cnt_d = cnt_q + 1'b1;
  end

  // Reported to the top so busy can be registered in step with the counter.
  assign active = (cnt_d != '0);

  // Synchroniser chain; keeps sampling even when enable is low.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the sync flops are reset too, so a reset release cannot see a
    // stale level and fake a transition on clean.
    if (!rst) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], dirty};
  end

  // Counter, clean level and edge pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      clean <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values of its neighbours, independent of statement order.
      cnt_q <= cnt_d;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (differs && at_limit) begin
        clean <= s;
        rise  <= s;
        fall  <= ~s;
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// N-channel switch/button debouncer: one debounce_channel per input plus a
// registered busy flag covering all channels.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int   CHANNELS    = 4,
  parameter int   CNT_W       = DEFAULT_CNT_W,
  parameter int   LIMIT       = DEFAULT_LIMIT,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CHANNELS-1:0] dirty,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                busy
);

  // Reject parameter sets the datapath cannot honour.
  if (CHANNELS < 1) begin : g_bad_channels
    $error("debounce_multi: CHANNELS must be >= 1");
  end
  if (LIMIT < 1) begin : g_bad_limit
    $error("debounce_multi: LIMIT must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be >= 2");
  end
  if (CNT_W < min_cnt_w(LIMIT)) begin : g_bad_cnt_w
    $error("debounce_multi: CNT_W too narrow to hold LIMIT-1");
  end

  logic [CHANNELS-1:0] active;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .LIMIT      (LIMIT),
      .SYNC_STAGES(SYNC_STAGES),
      .RESET_VAL  (RESET_VAL)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .enable(enable),
      .dirty (dirty[i]),
      .clean (clean[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .active(active[i])
    );
  end

  // busy tracks the counters as they will be after this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= 1'b0;
    else      busy <= |active;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with a pulse scoreboard: stimulus pushes
// the expected pulse (cycle, rise, fall, clean); a monitor pops on every
// observed pulse and compares.
module tb_debounce_multi;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b1;
  logic [N-1:0] dirty = '0;
  logic [N-1:0] clean, rise, fall;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int           cyc;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] clean;
  } ev_t;

  ev_t exp_q[$];

  debounce_multi #(
    .CHANNELS   (N),
    .CNT_W      (4),
    .LIMIT      (8),
    .SYNC_STAGES(2),
    .RESET_VAL  (1'b0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .dirty (dirty),
    .clean (clean),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Posedge counter; read #1 after an edge it equals the number of edges seen.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int at, input logic [N-1:0] r,
                              input logic [N-1:0] f, input logic [N-1:0] c);
    ev_t e;
    e.cyc = at; e.rise = r; e.fall = f; e.clean = c;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    dirty = '0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
  endtask

  // Monitor: every cycle with a pulse must match the next expected event.
  always @(negedge clk) begin
    if ((rise | fall) != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {rise, fall}, '0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_rise", rise, e.rise);
        check("pulse_fall", fall, e.fall);
        check("pulse_clean", clean, e.clean);
      end
    end
  end

  initial begin
    int n0;

    // 1. Reset with all inputs high, then release.
    #1 rst = 1'b0;
    dirty = 4'hF;
    step(2);
    check("rst_clean", clean, 4'h0);
    check("rst_rise", rise, 4'h0);
    check("rst_fall", fall, 4'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    n0 = cyc;
    expect_pulse(n0 + 10, 4'hF, 4'h0, 4'hF);
    step(3);
    check("rel_busy_counting", busy, 1'b1);
    check("rel_clean_held", clean, 4'h0);
    step(10);
    check("rel_clean_final", clean, 4'hF);
    apply_reset();
    check("rst2_clean", clean, 4'h0);

    // 2. Clean step on channel 0.
    dirty = 4'b0001;
    n0 = cyc;
    expect_pulse(n0 + 10, 4'b0001, 4'b0000, 4'b0001);
    step(2);
    check("step_busy_sync", busy, 1'b0);
    step(3);
    check("step_busy_mid", busy, 1'b1);
    check("step_clean_mid", clean, 4'b0000);
    step(4);
    check("step_clean_before", clean, 4'b0000);
    step(2);
    check("step_clean_after", clean, 4'b0001);
    check("step_busy_after", busy, 1'b0);
    apply_reset();

    // 3. Bounce on channel 1: high 5, low 1, high 20.
    dirty = 4'b0010;
    n0 = cyc;
    expect_pulse(n0 + 16, 4'b0010, 4'b0000, 4'b0010);
    step(5);
    dirty = 4'b0000;
    step(1);
    dirty = 4'b0010;
    step(6);
    check("bounce_no_early_flip", clean, 4'b0000);
    step(14);
    check("bounce_clean_final", clean, 4'b0010);
    apply_reset();

    // 4. Parallel flips on channels 1 and 3.
    dirty = 4'b1010;
    n0 = cyc;
    expect_pulse(n0 + 10, 4'b1010, 4'b0000, 4'b1010);
    step(30);
    check("par_clean_high", clean, 4'b1010);
    dirty = 4'b0000;
    expect_pulse(n0 + 40, 4'b0000, 4'b1010, 4'b0000);
    step(12);
    check("par_clean_low", clean, 4'b0000);

    // 5. Enable dropped at counter=5 for 3 cycles.
    dirty = 4'b0001;
    n0 = cyc;
    step(7);
    check("en_busy_before", busy, 1'b1);
    enable = 1'b0;
    step(1);
    check("en_busy_cleared", busy, 1'b0);
    step(2);
    check("en_clean_held", clean, 4'b0000);
    enable = 1'b1;
    expect_pulse(n0 + 18, 4'b0001, 4'b0000, 4'b0001);
    step(7);
    check("en_no_early_flip", clean, 4'b0000);
    step(2);
    check("en_clean_after", clean, 4'b0001);
    apply_reset();

    // 6. Reset at counter=6 on channel 2 while clean[2]=1.
    dirty = 4'b0100;
    n0 = cyc;
    expect_pulse(n0 + 10, 4'b0100, 4'b0000, 4'b0100);
    step(12);
    dirty = 4'b0000;
    step(8);
    check("mid_busy_counting", busy, 1'b1);
    check("mid_clean_before", clean, 4'b0100);
    rst = 1'b0;
    dirty = 4'b0100;
    #1;
    check("mid_rst_clean", clean, 4'b0000);
    check("mid_rst_fall", fall, 4'b0000);
    check("mid_rst_busy", busy, 1'b0);
    step(2);
    rst = 1'b1;
    n0 = cyc;
    expect_pulse(n0 + 10, 4'b0100, 4'b0000, 4'b0100);
    step(12);
    check("mid_clean_final", clean, 4'b0100);
    apply_reset();

    step(2);
    check("pending_expected_pulses", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
